// File: rtl/ks_pkg.sv
`timescale 1ns/1ps
// Shared Kogge-Stone helpers for the adder/subtractor family.
// Level count and the black/gray prefix combine cells.
package ks_pkg;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // Returns {G, P} for a black cell.
  function automatic logic [1:0] ks_black(
    input logic g_hi,
    input logic p_hi,
    input logic g_lo,
    input logic p_lo
  );
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  function automatic logic ks_gray(
    input logic g_hi,
    input logic p_hi,
    input logic g_lo
  );
    return g_hi | (p_hi & g_lo);
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
`timescale 1ns/1ps
// One registered Kogge-Stone prefix level with its valid bit.
// Bit propagate, carry-in and operand MSBs ride along unchanged.
module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SPAN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] pg_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             cin_i,
  input  logic             amsb_i,
  input  logic             bmsb_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] pg_o,
  output logic [WIDTH-1:0] p_o,
  output logic             cin_o,
  output logic             amsb_o,
  output logic             bmsb_o
);

  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] pg_d;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] pg_q;
  logic [WIDTH-1:0] p_q;
  logic             valid_q;
  logic             cin_q;
  logic             amsb_q;
  logic             bmsb_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i >= SPAN) begin : g_black
      assign {g_d[i], pg_d[i]} = ks_black(
        g_i[i], pg_i[i], g_i[i-SPAN], pg_i[i-SPAN]);
    end else begin : g_pass
      assign g_d[i]  = g_i[i];
      assign pg_d[i] = pg_i[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      g_q     <= '0;
      pg_q    <= '0;
      p_q     <= '0;
      cin_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      g_q     <= g_d;
      pg_q    <= pg_d;
      p_q     <= p_i;
      cin_q   <= cin_i;
      amsb_q  <= amsb_i;
      bmsb_q  <= bmsb_i;
    end
  end

  assign valid_o = valid_q;
  assign g_o     = g_q;
  assign pg_o    = pg_q;
  assign p_o     = p_q;
  assign cin_o   = cin_q;
  assign amsb_o  = amsb_q;
  assign bmsb_o  = bmsb_q;

endmodule

// File: rtl/kogge_stone_sub_pipe.sv
`timescale 1ns/1ps
// Pipelined Kogge-Stone subtractor: diff = a + ~b + ~bin.
// One register per prefix level, global stall on output backpressure.
module kogge_stone_sub_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int LEVELS  = ks_levels(WIDTH);
  localparam int LATENCY = LEVELS + 2;

  if (WIDTH < 4 || WIDTH > 64 ||
      (WIDTH & (WIDTH - 1)) != 0 ||
      LATENCY != LEVELS + 2) begin : g_bad_width
    $error("WIDTH must be a power of two in 4..64");
  end

  logic adv;

  logic [WIDTH-1:0] p0_d;
  logic [WIDTH-1:0] g0_d;
  logic             cin0_d;

  logic             v0_q;
  logic [WIDTH-1:0] p0_q;
  logic [WIDTH-1:0] g0_q;
  logic             cin0_q;
  logic             am0_q;
  logic             bm0_q;

  logic             vld_s [LEVELS+1];
  logic [WIDTH-1:0] g_s   [LEVELS+1];
  logic [WIDTH-1:0] pg_s  [LEVELS+1];
  logic [WIDTH-1:0] p_s   [LEVELS+1];
  logic             cin_s [LEVELS+1];
  logic             am_s  [LEVELS+1];
  logic             bm_s  [LEVELS+1];

  logic [WIDTH:0]   carry_d;
  logic [WIDTH:0]   carry_q;
  logic             cv_q;
  logic [WIDTH-1:0] cp_q;
  logic             ca_q;
  logic             cb_q;

  logic [WIDTH-1:0] diff_d;
  logic             bout_d;
  logic             zero_d;
  logic             neg_d;
  logic             ovf_d;

  logic             ov_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  assign adv      = !ov_q || out_ready;
  assign in_ready = adv;

  assign p0_d   = a ^ ~b;
  assign g0_d   = a & ~b;
  assign cin0_d = ~bin;

  // Operands are captured only with a valid beat, so idle-bus
  // garbage never enters the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      p0_q   <= '0;
      g0_q   <= '0;
      cin0_q <= 1'b0;
      am0_q  <= 1'b0;
      bm0_q  <= 1'b0;
    end else if (adv) begin
      v0_q <= in_valid;
      if (in_valid) begin
        p0_q   <= p0_d;
        g0_q   <= g0_d;
        cin0_q <= cin0_d;
        am0_q  <= a[WIDTH-1];
        bm0_q  <= b[WIDTH-1];
      end
    end
  end

  assign vld_s[0] = v0_q;
  assign g_s[0]   = g0_q;
  assign pg_s[0]  = p0_q;
  assign p_s[0]   = p0_q;
  assign cin_s[0] = cin0_q;
  assign am_s[0]  = am0_q;
  assign bm_s[0]  = bm0_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    ks_prefix_stage #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k - 1))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .valid_i (vld_s[k-1]),
      .g_i     (g_s[k-1]),
      .pg_i    (pg_s[k-1]),
      .p_i     (p_s[k-1]),
      .cin_i   (cin_s[k-1]),
      .amsb_i  (am_s[k-1]),
      .bmsb_i  (bm_s[k-1]),
      .valid_o (vld_s[k]),
      .g_o     (g_s[k]),
      .pg_o    (pg_s[k]),
      .p_o     (p_s[k]),
      .cin_o   (cin_s[k]),
      .amsb_o  (am_s[k]),
      .bmsb_o  (bm_s[k])
    );
  end

  always_comb begin
    carry_d    = '0;
    carry_d[0] = cin_s[LEVELS];
    for (int i = 0; i < WIDTH; i++) begin
      carry_d[i+1] = ks_gray(g_s[LEVELS][i],
                             pg_s[LEVELS][i],
                             cin_s[LEVELS]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q    <= 1'b0;
      carry_q <= '0;
      cp_q    <= '0;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
    end else if (adv) begin
      cv_q    <= vld_s[LEVELS];
      carry_q <= carry_d;
      cp_q    <= p_s[LEVELS];
      ca_q    <= am_s[LEVELS];
      cb_q    <= bm_s[LEVELS];
    end
  end

  assign diff_d = cp_q ^ carry_q[WIDTH-1:0];
  assign bout_d = ~carry_q[WIDTH];
  assign zero_d = (diff_d == '0);
  assign neg_d  = diff_d[WIDTH-1];
  assign ovf_d  = (ca_q ^ cb_q) & (diff_d[WIDTH-1] ^ ca_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      ov_q   <= cv_q;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = ov_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_kogge_stone_sub_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for kogge_stone_sub_pipe at WIDTH=8 and 32.
// Directed spec vectors, stall/reset scenarios, random runs vs a model.
module tb_kogge_stone_sub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv8, ir8, bi8, ov8, or8, bo8, z8, n8, f8;
  logic [7:0] a8, b8, d8;
  logic iv32, ir32, bi32, ov32, or32, bo32, z32, n32, f32;
  logic [31:0] a32, b32, d32;

  logic [35:0] obs8, obs32;
  assign obs8  = {f8, n8, z8, bo8, 24'd0, d8};
  assign obs32 = {f32, n32, z32, bo32, d32};

  int checks = 0;
  int passes = 0;
  logic [35:0] q8[$];
  logic [35:0] q32[$];

  kogge_stone_sub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bi8),
    .out_valid(ov8), .out_ready(or8),
    .diff(d8), .bout(bo8), .zero(z8),
    .neg(n8), .ovf(f8)
  );

  kogge_stone_sub_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .bin(bi32),
    .out_valid(ov32), .out_ready(or32),
    .diff(d32), .bout(bo32), .zero(z32),
    .neg(n32), .ovf(f32)
  );

  // {ovf, neg, zero, bout, diff[31:0]} from plain integer arithmetic
  function automatic logic [35:0] model(
    input int w, input longint a, input longint b,
    input longint bin);
    longint half, mask, full, d, sa, sb, sd;
    logic [35:0] r;
    half = 64'sd1 <<< (w - 1);
    mask = (half * 2) - 1;
    full = a - b - bin;
    d = full & mask;
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    sd = sa - sb - bin;
    r = '0;
    r[31:0] = d[31:0];
    r[32] = (full < 0);
    r[33] = (d == 0);
    r[34] = (d >= half);
    r[35] = (sd < -half) || (sd >= half);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; bi8 = 0;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; bi32 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0 || obs8 !== 36'd0)
      $display("FAIL reset8 got v=%b %h want v=0 0", ov8, obs8);
    else passes++;
    checks++;
    if (ov32 !== 1'b0 || obs32 !== 36'd0)
      $display("FAIL reset32 got v=%b %h want v=0 0", ov32, obs32);
    else passes++;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (ir8 !== 1'b1 || ir32 !== 1'b1)
      $display("FAIL reset_rdy got %b%b want 11", ir8, ir32);
    else passes++;
  endtask

  task automatic test_latency;
    iv8 = 1; a8 = 8'h00; b8 = 8'h01; bi8 = 0; or8 = 1;
    #1;
    checks++;
    if (ir8 !== 1'b1) $display("FAIL lat_rdy got %b want 1", ir8);
    else passes++;
    tick;
    iv8 = 0;
    for (int n = 0; n <= 5; n++) begin
      #1;
      checks++;
      if (ov8 !== (n == 5))
        $display("FAIL lat_valid edge%0d got %b want %b",
                 n, ov8, (n == 5));
      else passes++;
      if (n < 5) tick;
    end
    checks++;
    if (obs8 !== {4'b0101, 24'd0, 8'hFF})
      $display("FAIL lat_data got %h want %h",
               obs8, {4'b0101, 24'd0, 8'hFF});
    else passes++;
    tick;
  endtask

  task automatic test_vectors;
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic vc [6];
    logic [35:0] ve [6];
    int w;
    va[0] = 8'h00; vb[0] = 8'h01; vc[0] = 0;
    ve[0] = {4'b0101, 24'd0, 8'hFF};
    va[1] = 8'h80; vb[1] = 8'h01; vc[1] = 0;
    ve[1] = {4'b1000, 24'd0, 8'h7F};
    va[2] = 8'h7F; vb[2] = 8'hFF; vc[2] = 0;
    ve[2] = {4'b1101, 24'd0, 8'h80};
    va[3] = 8'h10; vb[3] = 8'h0F; vc[3] = 1;
    ve[3] = {4'b0010, 24'd0, 8'h00};
    va[4] = 8'h00; vb[4] = 8'hFF; vc[4] = 1;
    ve[4] = {4'b0011, 24'd0, 8'h00};
    va[5] = 8'h5A; vb[5] = 8'h5A; vc[5] = 0;
    ve[5] = {4'b0010, 24'd0, 8'h00};
    or8 = 1;
    for (int i = 0; i < 6; i++) begin
      iv8 = 1; a8 = va[i]; b8 = vb[i]; bi8 = vc[i];
      #1;
      tick;
      iv8 = 0;
      w = 0;
      #1;
      while (!ov8 && w < 10) begin
        tick;
        #1;
        w++;
      end
      checks++;
      if (ov8 !== 1'b1 || obs8 !== ve[i])
        $display("FAIL vec%0d got v=%b %h want v=1 %h",
                 i, ov8, obs8, ve[i]);
      else passes++;
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, recv = 0, gaps = 0, stalls = 0, cyc = 0;
    logic [35:0] e;
    or8 = 1;
    while (recv < 10 && cyc < 40) begin
      if (sent < 10) begin
        iv8 = 1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        bi8 = 1'($urandom);
      end else iv8 = 0;
      #1;
      if (!ir8) stalls++;
      if (ov8) begin
        e = (q8.size() > 0) ? q8.pop_front() : '1;
        checks++;
        if (obs8 !== e)
          $display("FAIL b2b beat%0d got %h want %h", recv, obs8, e);
        else passes++;
        recv++;
      end else if (recv > 0) gaps++;
      if (iv8 && ir8) begin
        q8.push_back(model(8, a8, b8, bi8));
        sent++;
      end
      tick;
      cyc++;
    end
    iv8 = 0;
    checks++;
    if (recv != 10) $display("FAIL b2b_count got %0d want 10", recv);
    else passes++;
    checks++;
    if (gaps != 0 || stalls != 0)
      $display("FAIL b2b_gaps got %0d/%0d want 0/0", gaps, stalls);
    else passes++;
  endtask

  task automatic test_stall;
    int sent = 0, recv = 0, gaps = 0, cyc = 0;
    bit pend = 0;
    logic [35:0] head, e;
    or8 = 0;
    repeat (12) begin
      if (!pend) begin
        pend = 1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        bi8 = 1'($urandom);
      end
      iv8 = 1;
      #1;
      if (ir8) begin
        q8.push_back(model(8, a8, b8, bi8));
        sent++;
        pend = 0;
      end
      tick;
    end
    checks++;
    if (sent != 6) $display("FAIL stall_fill got %0d want 6", sent);
    else passes++;
    head = q8[0];
    repeat (7) begin
      #1;
      checks++;
      if (ir8 !== 1'b0 || ov8 !== 1'b1 || obs8 !== head)
        $display("FAIL stall_hold got r=%b v=%b %h want r=0 v=1 %h",
                 ir8, ov8, obs8, head);
      else passes++;
      tick;
    end
    or8 = 1;
    while (recv < 10 && cyc < 40) begin
      if (!pend && sent < 10) begin
        pend = 1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        bi8 = 1'($urandom);
      end
      iv8 = pend;
      #1;
      if (ov8) begin
        e = (q8.size() > 0) ? q8.pop_front() : '1;
        checks++;
        if (obs8 !== e)
          $display("FAIL drain beat%0d got %h want %h", recv, obs8, e);
        else passes++;
        recv++;
      end else gaps++;
      if (iv8 && ir8) begin
        q8.push_back(model(8, a8, b8, bi8));
        sent++;
        pend = 0;
      end
      tick;
      cyc++;
    end
    iv8 = 0;
    checks++;
    if (recv != 10 || gaps != 0)
      $display("FAIL drain got %0d gaps=%0d want 10 gaps=0", recv, gaps);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int stale = 0, lat = 0;
    logic [35:0] e;
    or8 = 1;
    for (int i = 0; i < 3; i++) begin
      iv8 = 1;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      #1;
      tick;
    end
    iv8 = 0;
    rst_n = 0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || obs8 !== 36'd0)
      $display("FAIL rst_mid got v=%b %h want v=0 0", ov8, obs8);
    else passes++;
    q8.delete();
    tick;
    rst_n = 1;
    #1;
    checks++;
    if (ir8 !== 1'b1) $display("FAIL rst_mid_rdy got %b want 1", ir8);
    else passes++;
    repeat (10) begin
      #1;
      if (ov8) stale++;
      tick;
    end
    checks++;
    if (stale != 0) $display("FAIL rst_stale got %0d want 0", stale);
    else passes++;
    iv8 = 1;
    a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    e = model(8, a8, b8, bi8);
    #1;
    tick;
    iv8 = 0;
    #1;
    while (!ov8 && lat < 10) begin
      tick;
      #1;
      lat++;
    end
    checks++;
    if (lat != 5 || obs8 !== e)
      $display("FAIL rst_relat got lat=%0d %h want lat=5 %h",
               lat, obs8, e);
    else passes++;
    tick;
  endtask

  task automatic test_random8;
    int sent = 0, recv = 0, cyc = 0;
    bit pend = 0;
    logic [35:0] e;
    while (recv < 10000 && cyc < 25000) begin
      if (!pend && sent < 10000 && ($urandom % 4) != 0) begin
        pend = 1;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      end else if (!pend) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      end
      iv8 = pend;
      or8 = ($urandom % 4) != 0;
      #1;
      if (ov8 && or8) begin
        e = (q8.size() > 0) ? q8.pop_front() : '1;
        checks++;
        if (obs8 !== e)
          $display("FAIL rnd8 beat%0d got %h want %h", recv, obs8, e);
        else passes++;
        recv++;
      end
      if (iv8 && ir8) begin
        q8.push_back(model(8, a8, b8, bi8));
        sent++;
        pend = 0;
      end
      tick;
      cyc++;
    end
    iv8 = 0;
    or8 = 1;
    checks++;
    if (recv != 10000)
      $display("FAIL rnd8_count got %0d want 10000", recv);
    else passes++;
  endtask

  task automatic test_random32;
    int sent = 0, recv = 0, cyc = 0;
    bit pend = 0;
    logic [35:0] e;
    while (recv < 10000 && cyc < 25000) begin
      if (!pend && sent < 10000 && ($urandom % 4) != 0) begin
        pend = 1;
        a32 = $urandom; b32 = $urandom; bi32 = 1'($urandom);
        if (($urandom % 8) == 0) b32 = a32;
      end else if (!pend) begin
        a32 = $urandom; b32 = $urandom; bi32 = 1'($urandom);
      end
      iv32 = pend;
      or32 = ($urandom % 4) != 0;
      #1;
      if (ov32 && or32) begin
        e = (q32.size() > 0) ? q32.pop_front() : '1;
        checks++;
        if (obs32 !== e)
          $display("FAIL rnd32 beat%0d got %h want %h", recv, obs32, e);
        else passes++;
        recv++;
      end
      if (iv32 && ir32) begin
        q32.push_back(model(32, a32, b32, bi32));
        sent++;
        pend = 0;
      end
      tick;
      cyc++;
    end
    iv32 = 0;
    or32 = 1;
    checks++;
    if (recv != 10000)
      $display("FAIL rnd32_count got %0d want 10000", recv);
    else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_latency;
    test_vectors;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_random8;
    test_random32;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
